// File: rtl/tk1_spi_target.sv
// ---------------------------------------------------------------------------
// tk1_spi_target
//
// SPI mode-0 target (slave), MSB first. This is the responding end of the tk1
// SPI master link, used for board bring-up and for loop-back of the host-side
// master. The pad signals SS/SCK/MOSI are asynchronous to clk. They are
// oversampled through a synchroniser, and edges are detected on the
// synchronised copies. One byte is exchanged for every 8 SCK cycles.
//
// Core side:
//   - one-entry TX buffer   (tx_data / tx_data_vld / tx_ready)
//   - one-entry RX register (rx_data / rx_data_vld / rx_ack)
//
// Parameters
//   SYNC_STAGES  synchroniser depth on spi_ss/spi_sck/spi_mosi (>= 2)
//   FILL_BYTE    byte shifted out when the TX buffer is empty (underrun)
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   spi_ss       in   1  chip select, active low (asynchronous to clk)
//   spi_sck      in   1  SPI clock, idle low, f_sck <= f_clk/8
//   spi_mosi     in   1  data from master
//   spi_miso     out  1  data to master
//   spi_miso_en  out  1  output enable for the MISO pad driver
//   tx_data      in   8  next byte to send
//   tx_data_vld  in   1  tx_data valid, accepted when tx_ready=1
//   tx_ready     out  1  TX buffer empty
//   rx_data      out  8  last received byte
//   rx_data_vld  out  1  rx_data holds an unacknowledged byte
//   rx_ack       in   1  consume rx_data
//   spi_active   out  1  transaction in progress (FSM in SHIFT)
//
// Optional feature, macro TK1_SPI_TARGET_STATUS_EN:
//   status_clr   in   1  clear the sticky status flags
//   overrun      out  1  sticky: a byte replaced an unacknowledged byte
//   underrun     out  1  sticky: FILL_BYTE was loaded because TX was empty
//   When the macro is undefined, these ports do not exist. The data path is
//   the same in both builds.
// ---------------------------------------------------------------------------
module tk1_spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_en,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    input  logic       rx_ack,
`ifdef TK1_SPI_TARGET_STATUS_EN
    input  logic       status_clr,
    output logic       overrun,
    output logic       underrun,
`endif
    output logic       spi_active
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_prev_q;
    logic                   sck_prev_q;

    logic ss_s;
    logic sck_s;
    logic mosi_s;
    logic ss_fall;
    logic ss_rise;
    logic sck_rise;
    logic sck_fall;

    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The edge is seen combinationally one stage after the synchroniser
    // output. Acting on it at the next clk edge gives a total latency of
    // SYNC_STAGES+1 clk from the pad.
    assign ss_fall  =  ss_prev_q  & ~ss_s;
    assign ss_rise  = ~ss_prev_q  &  ss_s;
    assign sck_rise = ~sck_prev_q &  sck_s;
    assign sck_fall =  sck_prev_q & ~sck_s;

    // NOTE: sequential state always uses non-blocking (<=) assignments, so
    // every flop samples values from before the clock edge. A blocking
    // assignment here would make later stages see the new value in the same
    // edge, which collapses the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   spi_ss};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ss_prev_q   <= ss_s;
            sck_prev_q  <= sck_s;
        end
    end

    // -----------------------------------------------------------------------
    // Protocol state
    // -----------------------------------------------------------------------
    state_e     state_q,      state_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] shift_tx_q,   shift_tx_d;
    // Only seven bits are held. The eighth bit is taken straight from MOSI
    // when the byte completes.
    logic [6:0] shift_rx_q,   shift_rx_d;
    logic [7:0] txbuf_q,      txbuf_d;
    logic       txbuf_full_q, txbuf_full_d;
    logic [7:0] rx_data_q,    rx_data_d;
    logic       rx_vld_q,     rx_vld_d;

    logic       reload;     // load shift_tx from the TX buffer or FILL_BYTE
    logic       byte_done;  // eighth SCK rise of a byte

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_tx_q   <= 8'h00;
            shift_rx_q   <= 7'h00;
            txbuf_q      <= 8'h00;
            txbuf_full_q <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_tx_q   <= shift_tx_d;
            shift_rx_q   <= shift_rx_d;
            txbuf_q      <= txbuf_d;
            txbuf_full_q <= txbuf_full_d;
            rx_data_q    <= rx_data_d;
            rx_vld_q     <= rx_vld_d;
        end
    end

    // NOTE: every signal written in this block gets a default value first.
    // Because of that, no path can leave it unassigned, and no latch is
    // inferred.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_tx_d   = shift_tx_q;
        shift_rx_d   = shift_rx_q;
        txbuf_d      = txbuf_q;
        txbuf_full_d = txbuf_full_q;
        rx_data_d    = rx_data_q;
        rx_vld_d     = rx_vld_q;
        reload       = 1'b0;
        byte_done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // SCK activity is ignored while deselected.
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 3'd0;
                    reload    = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Deselect takes priority over any SCK edge in the same
                // cycle. A partial byte is dropped without signalling.
                if (ss_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    shift_rx_d = {shift_rx_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    byte_done  = (bit_cnt_q == 3'd7);
                end else if (sck_fall) begin
                    // A count of zero on a falling edge means the eighth bit
                    // has just been sampled by the master. The next byte
                    // starts here.
                    if (bit_cnt_q != 3'd0) begin
                        shift_tx_d = {shift_tx_q[6:0], 1'b0};
                    end else begin
                        reload = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            shift_tx_d = txbuf_full_q ? txbuf_q : FILL_BYTE;
        end

        // A reload empties the buffer only if it was full. A write is
        // accepted only if it was empty. The two cannot collide, so a write
        // in the reload cycle stays in the buffer for the following byte.
        if (reload && txbuf_full_q) begin
            txbuf_full_d = 1'b0;
        end
        if (tx_data_vld && !txbuf_full_q) begin
            txbuf_d      = tx_data;
            txbuf_full_d = 1'b1;
        end

        // A completed byte always lands, even over an unacknowledged one.
        if (byte_done) begin
            rx_data_d = {shift_rx_q, mosi_s};
            rx_vld_d  = 1'b1;
        end else if (rx_ack) begin
            rx_vld_d  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Optional sticky status flags
    // -----------------------------------------------------------------------
`ifdef TK1_SPI_TARGET_STATUS_EN
    logic overrun_q,  overrun_d;
    logic underrun_q, underrun_d;
    logic overrun_set;
    logic underrun_set;

    assign overrun_set  = byte_done && rx_vld_q && !rx_ack;
    assign underrun_set = reload && !txbuf_full_q;

    // A set event in the same cycle as status_clr wins.
    always_comb begin
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (status_clr) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign overrun  = overrun_q;
    assign underrun = underrun_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign spi_active  = (state_q == ST_SHIFT);
    assign spi_miso_en = spi_active;
    assign spi_miso    = spi_active & shift_tx_q[7];
    assign tx_ready    = ~txbuf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_data_vld = rx_vld_q;

endmodule

// File: tb/tb_tk1_spi_target.sv
// ---------------------------------------------------------------------------
// tb_tk1_spi_target
//
// Directed testbench for tk1_spi_target. A behavioural SPI mode-0 master is
// built from tasks, with SCK half period = 4 clk (f_sck = f_clk/8). Outputs
// are sampled on the falling edge of clk. Inputs are changed right after a
// falling edge. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tk1_spi_target;

    logic       clk;
    logic       reset;
    logic       spi_ss;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_en;
    logic [7:0] tx_data;
    logic       tx_data_vld;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_data_vld;
    logic       rx_ack;
    logic       spi_active;
`ifdef TK1_SPI_TARGET_STATUS_EN
    logic       status_clr;
    logic       overrun;
    logic       underrun;
`endif

    int total = 0;
    int bad   = 0;

    tk1_spi_target #(
        .SYNC_STAGES (2),
        .FILL_BYTE   (8'hff)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_ss      (spi_ss),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_en (spi_miso_en),
        .tx_data     (tx_data),
        .tx_data_vld (tx_data_vld),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_data_vld (rx_data_vld),
        .rx_ack      (rx_ack),
`ifdef TK1_SPI_TARGET_STATUS_EN
        .status_clr  (status_clr),
        .overrun     (overrun),
        .underrun    (underrun),
`endif
        .spi_active  (spi_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".miso"},     {31'd0, spi_miso},    32'd0);
        check({tag, ".miso_en"},  {31'd0, spi_miso_en}, 32'd0);
        check({tag, ".tx_ready"}, {31'd0, tx_ready},    32'd1);
        check({tag, ".rx_data"},  {24'd0, rx_data},     32'h00);
        check({tag, ".rx_vld"},   {31'd0, rx_data_vld}, 32'd0);
        check({tag, ".active"},   {31'd0, spi_active},  32'd0);
`ifdef TK1_SPI_TARGET_STATUS_EN
        check({tag, ".overrun"},  {31'd0, overrun},     32'd0);
        check({tag, ".underrun"}, {31'd0, underrun},    32'd0);
`endif
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_data     = d;
        tx_data_vld = 1'b1;
        @(negedge clk);
        tx_data_vld = 1'b0;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

`ifdef TK1_SPI_TARGET_STATUS_EN
    task automatic clr_pulse();
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask
`endif

    task automatic ss_low();
        spi_ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic ss_high();
        spi_ss = 1'b1;
        wait_clk(4);
    endtask

    // One byte, MSB first. MISO is sampled just before each rising SCK.
    // ack_done: raise rx_ack exactly in the byte-done cycle. The sync delay
    //   is 2 clk, so the byte is stored on the 3rd posedge after the last
    //   rising SCK.
    // wr_reload: write wr_data in the same cycle as the byte-boundary reload
    //   (3rd posedge after the last falling SCK).
    task automatic xfer(input logic [7:0] mo, output logic [7:0] mi,
                        input bit ack_done, input bit wr_reload, input logic [7:0] wr_data);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = mo[i];
            wait_clk(4);
            mi[i]   = spi_miso;
            spi_sck = 1'b1;
            if (ack_done && i == 0) begin
                wait_clk(2);
                rx_ack = 1'b1;
                wait_clk(1);
                rx_ack = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
            spi_sck = 1'b0;
        end
        if (wr_reload) begin
            wait_clk(2);
            tx_data     = wr_data;
            tx_data_vld = 1'b1;
            wait_clk(1);
            tx_data_vld = 1'b0;
            wait_clk(1);
        end else begin
            wait_clk(4);
        end
    endtask

    logic [7:0] mi;

    initial begin
        reset       = 1'b1;
        spi_ss      = 1'b1;
        spi_sck     = 1'b0;
        spi_mosi    = 1'b0;
        tx_data     = 8'h00;
        tx_data_vld = 1'b0;
        rx_ack      = 1'b0;
`ifdef TK1_SPI_TARGET_STATUS_EN
        status_clr  = 1'b0;
`endif
        wait_clk(5);
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_clk(3);

        // 1: preloaded A5, master sends 3C
        tx_write(8'hA5);
        check("t1.tx_ready_full", {31'd0, tx_ready}, 32'd0);
        ss_low();
        check("t1.tx_ready_after_ss", {31'd0, tx_ready}, 32'd1);
        check("t1.active", {31'd0, spi_active}, 32'd1);
        check("t1.miso_en", {31'd0, spi_miso_en}, 32'd1);
        xfer(8'h3C, mi, 1'b0, 1'b0, 8'h00);
        check("t1.miso_byte", {24'd0, mi}, 32'hA5);
        check("t1.rx_data", {24'd0, rx_data}, 32'h3C);
        check("t1.rx_vld", {31'd0, rx_data_vld}, 32'd1);
        ack_pulse();
        check("t1.rx_vld_acked", {31'd0, rx_data_vld}, 32'd0);
        ss_high();
        check("t1.miso_en_idle", {31'd0, spi_miso_en}, 32'd0);
        check("t1.active_idle", {31'd0, spi_active}, 32'd0);

        // 2: empty TX, two bytes within one select
        ss_low();
        xfer(8'h01, mi, 1'b0, 1'b0, 8'h00);
        check("t2.miso0", {24'd0, mi}, 32'hFF);
        check("t2.rx0", {24'd0, rx_data}, 32'h01);
        check("t2.vld0", {31'd0, rx_data_vld}, 32'd1);
        ack_pulse();
        check("t2.vld0_acked", {31'd0, rx_data_vld}, 32'd0);
        xfer(8'h02, mi, 1'b0, 1'b0, 8'h00);
        check("t2.miso1", {24'd0, mi}, 32'hFF);
        check("t2.rx1", {24'd0, rx_data}, 32'h02);
        check("t2.vld1", {31'd0, rx_data_vld}, 32'd1);
`ifdef TK1_SPI_TARGET_STATUS_EN
        check("t2.underrun", {31'd0, underrun}, 32'd1);
        check("t2.overrun", {31'd0, overrun}, 32'd0);
`endif
        ack_pulse();
        ss_high();

        // 3: aborted partial byte, then a full 81
        ss_low();
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            wait_clk(4);
            spi_sck = 1'b1;
            wait_clk(4);
            spi_sck = 1'b0;
        end
        wait_clk(4);
        ss_high();
        check("t3.vld_partial", {31'd0, rx_data_vld}, 32'd0);
        check("t3.miso_en", {31'd0, spi_miso_en}, 32'd0);
        check("t3.rx_kept", {24'd0, rx_data}, 32'h02);
        ss_low();
        xfer(8'h81, mi, 1'b0, 1'b0, 8'h00);
        check("t3.rx", {24'd0, rx_data}, 32'h81);
        check("t3.vld", {31'd0, rx_data_vld}, 32'd1);
        check("t3.miso", {24'd0, mi}, 32'hFF);
        ack_pulse();
        ss_high();

        // 4: overrun, two bytes without ack
`ifdef TK1_SPI_TARGET_STATUS_EN
        clr_pulse();
        check("t4.underrun_clr", {31'd0, underrun}, 32'd0);
`endif
        ss_low();
        xfer(8'h11, mi, 1'b0, 1'b0, 8'h00);
        xfer(8'h22, mi, 1'b0, 1'b0, 8'h00);
        check("t4.rx", {24'd0, rx_data}, 32'h22);
        check("t4.vld", {31'd0, rx_data_vld}, 32'd1);
`ifdef TK1_SPI_TARGET_STATUS_EN
        check("t4.overrun", {31'd0, overrun}, 32'd1);
        clr_pulse();
        check("t4.overrun_clr", {31'd0, overrun}, 32'd0);
`endif
        ack_pulse();
        ss_high();

        // 5: ack in the byte-done cycle; TX write in the reload cycle
`ifdef TK1_SPI_TARGET_STATUS_EN
        clr_pulse();
`endif
        ss_low();
        xfer(8'h33, mi, 1'b0, 1'b1, 8'hC3);
        check("t5.miso0", {24'd0, mi}, 32'hFF);
        check("t5.tx_ready_kept", {31'd0, tx_ready}, 32'd0);
        xfer(8'h44, mi, 1'b1, 1'b0, 8'h00);
        check("t5.miso1", {24'd0, mi}, 32'hFF);
        check("t5.rx1", {24'd0, rx_data}, 32'h44);
        check("t5.vld1", {31'd0, rx_data_vld}, 32'd1);
`ifdef TK1_SPI_TARGET_STATUS_EN
        check("t5.no_overrun", {31'd0, overrun}, 32'd0);
`endif
        check("t5.tx_ready_drained", {31'd0, tx_ready}, 32'd1);
        xfer(8'h55, mi, 1'b0, 1'b0, 8'h00);
        check("t5.miso2", {24'd0, mi}, 32'hC3);
        check("t5.rx2", {24'd0, rx_data}, 32'h55);
        ss_high();

        // 6: reset mid-byte with SCK toggling
        ss_low();
        spi_mosi = 1'b1;
        wait_clk(2);
        spi_sck = 1'b1;
        wait_clk(4);
        spi_sck = 1'b0;
        wait_clk(4);
        spi_sck = 1'b1;
        wait_clk(2);
        check("t6.pre_vld", {31'd0, rx_data_vld}, 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check_reset_outputs("t6.rst1");
        for (int i = 0; i < 8; i++) begin
            spi_sck = ~spi_sck;
            wait_clk(2);
        end
        check_reset_outputs("t6.rst_sck");
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(4);
        check_reset_outputs("t6.post");
        tx_write(8'h5A);
        ss_low();
        xfer(8'h5A, mi, 1'b0, 1'b0, 8'h00);
        check("t6.miso", {24'd0, mi}, 32'h5A);
        check("t6.rx", {24'd0, rx_data}, 32'h5A);
        check("t6.vld", {31'd0, rx_data_vld}, 32'd1);
        ss_high();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
